ucie_tx_credit_ctrl: RTL and testbench

Credit-gated transmit drain stage sitting directly downstream of the transmit `fifo_sync`. It pops flits from the FIFO's show-ahead head and holds each in a one-entry output register toward the link. It presents them on a valid/ready interface only while link-partner credits are available. It also coordinates drop-on-midreset flushing of both the FIFO and its own in-flight flit.

---
 rtl/ucie_tx_pkg.sv | 14 +
 rtl/ucie_credit_counter.sv | 54 +++++
 rtl/ucie_tx_credit_ctrl.sv | 121 ++++++++++++
 tb/tb_ucie_tx_credit_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ucie_tx_pkg.sv
// Shared types for the UCIe transmit credit controller: FSM state encoding and
// stall counter width.
package ucie_tx_pkg;

    localparam int unsigned STALL_CNT_W = 16;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StActive  = 2'd1,
        StCrdWait = 2'd2,
        StFlush   = 2'd3
    } tx_crd_state_e;

endpackage

// File: rtl/ucie_credit_counter.sv
// Saturating link-partner credit register: adds returned credits, subtracts
// consumed ones, reloads on flush and flags overflow (sticky until reset).
module ucie_credit_counter #(
    parameter int unsigned INIT_CREDITS = 4,
    parameter int unsigned MAX_CREDITS  = 15,
    parameter int unsigned CRD_RET_W    = 3
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               reload,
    input  logic                               ret_valid,
    input  logic [CRD_RET_W-1:0]               ret_cnt,
    input  logic                               consume,
    output logic [$clog2(MAX_CREDITS+1)-1:0]   crd,
    output logic [$clog2(MAX_CREDITS+1)-1:0]   crd_next,
    output logic                               ovf
);

    localparam int unsigned CRD_W = $clog2(MAX_CREDITS + 1);
    // One bit of headroom over the wider operand so the pre-clamp sum cannot wrap.
    localparam int unsigned SUM_W = ((CRD_W > CRD_RET_W) ? CRD_W : CRD_RET_W) + 1;
    localparam logic [SUM_W-1:0] MaxSum = SUM_W'(MAX_CREDITS);

    logic [SUM_W-1:0] sum;
    logic [CRD_W-1:0] crd_q, crd_d;
    logic             ovf_q, ovf_d;

    always_comb begin
        sum   = SUM_W'(crd_q) + (ret_valid ? SUM_W'(ret_cnt) : '0) - SUM_W'(consume);
        crd_d = sum[CRD_W-1:0];
        ovf_d = ovf_q;
        if (reload) begin
            crd_d = CRD_W'(INIT_CREDITS);
        end else if (sum > MaxSum) begin
            crd_d = CRD_W'(MAX_CREDITS);
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            crd_q <= CRD_W'(INIT_CREDITS);
            ovf_q <= 1'b0;
        end else begin
            crd_q <= crd_d;
            ovf_q <= ovf_d;
        end
    end

    assign crd      = crd_q;
    assign crd_next = crd_d;
    assign ovf      = ovf_q;

endmodule

// File: rtl/ucie_tx_credit_ctrl.sv
// Credit-gated drain stage behind the TX fifo_sync: pops show-ahead flits into a one-entry
// output register. Optional stall counter enabled by UCIE_TX_CRD_STALL_CNT_EN.
module ucie_tx_credit_ctrl
    import ucie_tx_pkg::*;
#(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned INIT_CREDITS = 4,
    parameter int unsigned MAX_CREDITS  = 15,
    parameter int unsigned CRD_RET_W    = 3
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             enable_i,
    input  logic                             flush_i,
    input  logic                             fifo_empty_i,
    input  logic [WIDTH-1:0]                 fifo_rdata_i,
    output logic                             fifo_pop_o,
    output logic                             fifo_clear_o,
    output logic                             tx_valid_o,
    output logic [WIDTH-1:0]                 tx_data_o,
    input  logic                             tx_ready_i,
    input  logic                             crd_ret_valid_i,
    input  logic [CRD_RET_W-1:0]             crd_ret_cnt_i,
    output logic [$clog2(MAX_CREDITS+1)-1:0] crd_avail_o,
    output logic [1:0]                       state_o,
    output logic                             crd_ovf_o,
    output logic [STALL_CNT_W-1:0]           crd_stall_cnt_o
);

    localparam int unsigned CRD_W = $clog2(MAX_CREDITS + 1);

    tx_crd_state_e    state_q, state_d;
    logic             pop, clear;
    logic             valid_q;
    logic [WIDTH-1:0] data_q;
    logic [CRD_W-1:0] crd, crd_next;

    // Flush actions (clear, drop, reload) take effect on the flush_i edge itself;
    // the FLUSH state is the one quiet cycle that follows.
    assign clear = flush_i && !rst_i;
    assign pop   = !rst_i && (state_q == StActive) && !fifo_empty_i && enable_i && !flush_i &&
                   (!valid_q || tx_ready_i);

    ucie_credit_counter #(
        .INIT_CREDITS (INIT_CREDITS),
        .MAX_CREDITS  (MAX_CREDITS),
        .CRD_RET_W    (CRD_RET_W)
    ) u_credit_counter (
        .clk       (clk_i),
        .rst       (rst_i),
        .reload    (flush_i),
        .ret_valid (crd_ret_valid_i),
        .ret_cnt   (crd_ret_cnt_i),
        .consume   (pop),
        .crd       (crd),
        .crd_next  (crd_next),
        .ovf       (crd_ovf_o)
    );

    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = StFlush;
        end else begin
            case (state_q)
                StIdle: begin
                    if (enable_i) state_d = (crd != '0) ? StActive : StCrdWait;
                end
                StActive, StCrdWait: begin
                    if (!enable_i) state_d = StIdle;
                    else           state_d = (crd_next != '0) ? StActive : StCrdWait;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= StIdle;
        else       state_q <= state_d;
    end

    // Held flit survives enable_i dropping; only acceptance or flush retires it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (flush_i) begin
            valid_q <= 1'b0;
        end else if (pop) begin
            valid_q <= 1'b1;
            data_q  <= fifo_rdata_i;
        end else if (tx_ready_i) begin
            valid_q <= 1'b0;
        end
    end

`ifdef UCIE_TX_CRD_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] stall_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_q <= '0;
        end else if ((state_q == StCrdWait) && !fifo_empty_i && (stall_q != '1)) begin
            stall_q <= stall_q + STALL_CNT_W'(1);
        end
    end

    assign crd_stall_cnt_o = stall_q;
`else
    assign crd_stall_cnt_o = '0;
`endif

    assign fifo_pop_o   = pop;
    assign fifo_clear_o = clear;
    assign tx_valid_o   = valid_q;
    assign tx_data_o    = data_q;
    assign crd_avail_o  = crd;
    assign state_o      = state_q;

endmodule

// File: tb/tb_ucie_tx_credit_ctrl.sv
// Self-checking bench for ucie_tx_credit_ctrl: directed table, corner sequences and
// randomized traffic against a cycle-level model of the credit/drain rules.
module tb_ucie_tx_credit_ctrl;

    localparam int INIT = 4;
    localparam int MAXC = 15;
`ifdef UCIE_TX_CRD_STALL_CNT_EN
    localparam bit STALL_EN = 1'b1;
`else
    localparam bit STALL_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, enable, flush, fifo_empty, tx_ready, crd_ret_valid;
    logic [31:0] fifo_rdata;
    logic [2:0]  crd_ret_cnt;
    logic        fifo_pop, fifo_clear, tx_valid, crd_ovf;
    logic [31:0] tx_data;
    logic [3:0]  crd_avail;
    logic [1:0]  state;
    logic [15:0] stall_cnt;

    ucie_tx_credit_ctrl dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .enable_i        (enable),
        .flush_i         (flush),
        .fifo_empty_i    (fifo_empty),
        .fifo_rdata_i    (fifo_rdata),
        .fifo_pop_o      (fifo_pop),
        .fifo_clear_o    (fifo_clear),
        .tx_valid_o      (tx_valid),
        .tx_data_o       (tx_data),
        .tx_ready_i      (tx_ready),
        .crd_ret_valid_i (crd_ret_valid),
        .crd_ret_cnt_i   (crd_ret_cnt),
        .crd_avail_o     (crd_avail),
        .state_o         (state),
        .crd_ovf_o       (crd_ovf),
        .crd_stall_cnt_o (stall_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model of the FIFO contents and the controller's visible state.
    logic [31:0] q[$];
    int          m_st, m_crd, m_stall, pops;
    bit          m_valid, m_ovf, last_pop, last_clear;
    logic [31:0] m_data;

    typedef struct {
        bit          en;
        bit          ready;
        bit          exp_pop;
        bit          exp_valid;
        logic [31:0] exp_data;
        int          exp_crd;
        int          exp_state;
    } vec_t;

    vec_t tbl[5];

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        bit m_pop;
        int sum, ncrd, nst;
        fifo_empty = (q.size() == 0);
        fifo_rdata = fifo_empty ? 32'h0 : q[0];
        #2;
        m_pop = !rst && m_st == 1 && !fifo_empty && enable && !flush && (!m_valid || tx_ready);
        chk("pop", fifo_pop, m_pop);
        chk("clear", fifo_clear, !rst && flush);
        last_pop   = fifo_pop;
        last_clear = fifo_clear;
        if (rst) begin
            m_st = 0; m_crd = INIT; m_valid = 0; m_data = 0; m_ovf = 0; m_stall = 0;
        end else begin
            sum = m_crd + (crd_ret_valid ? int'(crd_ret_cnt) : 0) - (m_pop ? 1 : 0);
            if (flush) ncrd = INIT;
            else if (sum > MAXC) begin ncrd = MAXC; m_ovf = 1; end
            else ncrd = sum;
            if (flush) nst = 3;
            else if (m_st == 0) nst = enable ? (m_crd > 0 ? 1 : 2) : 0;
            else if (m_st == 3) nst = 0;
            else nst = !enable ? 0 : (ncrd == 0 ? 2 : 1);
            if (STALL_EN && m_st == 2 && !fifo_empty && m_stall < 65535) m_stall++;
            if (flush) m_valid = 0;
            else if (m_pop) begin m_valid = 1; m_data = fifo_rdata; end
            else if (tx_ready) m_valid = 0;
            m_crd = ncrd;
            m_st  = nst;
        end
        @(posedge clk);
        #1;
        if (last_clear) q.delete();
        else if (last_pop && q.size() > 0) void'(q.pop_front());
        if (last_pop) pops++;
        chk("valid", tx_valid, m_valid);
        if (m_valid) chk("data", tx_data, m_data);
        chk("crd", crd_avail, m_crd);
        chk("state", state, m_st);
        chk("ovf", crd_ovf, m_ovf);
        chk("stall", stall_cnt, m_stall);
    endtask

    task automatic do_reset();
        rst = 1; enable = 0; flush = 0; tx_ready = 0; crd_ret_valid = 0; crd_ret_cnt = 0;
        q.delete();
        tick();
        tick();
        rst = 0;
        pops = 0;
    endtask

    task automatic push_n(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) q.push_back(base + 32'(i));
    endtask

    initial begin
        tbl[0] = '{1, 1, 0, 0, 32'h0, 4, 1};
        tbl[1] = '{1, 1, 1, 1, 32'hA, 3, 1};
        tbl[2] = '{1, 1, 1, 1, 32'hB, 2, 1};
        tbl[3] = '{1, 1, 1, 1, 32'hC, 1, 1};
        tbl[4] = '{1, 1, 0, 0, 32'h0, 1, 1};

        // Reset values
        do_reset();
        chk("rst_valid", tx_valid, 0);
        chk("rst_data", tx_data, 0);
        chk("rst_crd", crd_avail, INIT);
        chk("rst_state", state, 0);
        chk("rst_ovf", crd_ovf, 0);
        chk("rst_stall", stall_cnt, 0);

        // Three flits back-to-back
        push_n(3, 32'hA);
        for (int i = 0; i < 5; i++) begin
            enable = tbl[i].en;
            tx_ready = tbl[i].ready;
            tick();
            chk("t1_pop", last_pop, tbl[i].exp_pop);
            chk("t1_valid", tx_valid, tbl[i].exp_valid);
            if (tbl[i].exp_valid) chk("t1_data", tx_data, tbl[i].exp_data);
            chk("t1_crd", crd_avail, tbl[i].exp_crd);
            chk("t1_state", state, tbl[i].exp_state);
        end

        // Credit exhaustion then return of 2
        do_reset();
        push_n(6, 32'h20);
        enable = 1; tx_ready = 1;
        for (int i = 0; i < 20 && state != 2'd2; i++) tick();
        chk("t2_wait", state, 2);
        chk("t2_pops", pops, 4);
        chk("t2_crd0", crd_avail, 0);
        tick();
        chk("t2_nopop", last_pop, 0);
        crd_ret_valid = 1; crd_ret_cnt = 2;
        tick();
        crd_ret_valid = 0;
        chk("t2_ret_nopop", last_pop, 0);
        chk("t2_ret_crd", crd_avail, 2);
        tick();
        chk("t2_pop5", last_pop, 1);
        tick();
        chk("t2_pop6", last_pop, 1);
        chk("t2_wait2", state, 2);
        tick();
        chk("t2_total", pops, 6);

        // Backpressure holds the flit
        do_reset();
        push_n(3, 32'h31);
        enable = 1; tx_ready = 0;
        tick();
        tick();
        chk("t3_first", tx_data, 32'h31);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t3_hold_pop", last_pop, 0);
            chk("t3_hold_data", tx_data, 32'h31);
        end
        tx_ready = 1;
        tick();
        chk("t3_next", tx_data, 32'h32);
        tick();
        chk("t3_b2b", tx_data, 32'h33);

        // Overflow clamps and sticks through flush
        do_reset();
        crd_ret_valid = 1; crd_ret_cnt = 7;
        tick();
        crd_ret_cnt = 3;
        tick();
        chk("t4_crd14", crd_avail, 14);
        tick();
        chk("t4_clamp", crd_avail, 15);
        chk("t4_ovf", crd_ovf, 1);
        crd_ret_valid = 0; flush = 1;
        tick();
        flush = 0;
        tick();
        chk("t4_ovf_flush", crd_ovf, 1);
        chk("t4_reload", crd_avail, INIT);
        do_reset();
        chk("t4_ovf_rst", crd_ovf, 0);

        // Flush with a held flit
        do_reset();
        push_n(5, 32'h50);
        enable = 1; tx_ready = 1;
        repeat (4) tick();
        chk("t5_crd1", crd_avail, 1);
        chk("t5_valid", tx_valid, 1);
        flush = 1; tx_ready = 0;
        tick();
        chk("t5_clear", last_clear, 1);
        chk("t5_drop", tx_valid, 0);
        chk("t5_crd4", crd_avail, INIT);
        chk("t5_flush", state, 3);
        flush = 0;
        tick();
        chk("t5_clear_off", last_clear, 0);
        chk("t5_idle", state, 0);

        // Stall counter
        do_reset();
        push_n(6, 32'h60);
        enable = 1; tx_ready = 1;
        repeat (5) tick();
        chk("t6_wait", state, 2);
        repeat (5) tick();
        chk("t6_stall", stall_cnt, STALL_EN ? 5 : 0);

        // Randomized traffic against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst           = ($urandom_range(0, 599) == 0);
            enable        = ($urandom_range(0, 9) != 0);
            flush         = ($urandom_range(0, 39) == 0);
            tx_ready      = ($urandom_range(0, 3) != 0);
            crd_ret_valid = ($urandom_range(0, 3) == 0);
            crd_ret_cnt   = 3'($urandom_range(0, 7));
            if (q.size() < 8 && $urandom_range(0, 1) == 1) q.push_back($urandom);
            tick();
        end
        rst = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
